// File: rtl/tape_rec.sv
// Cassette capture: times rising edges of cass_out in ce_tape ticks, decodes
// 0/1 cycles into start/8-data/2-stop frames and writes good bytes to RAM.
module tape_rec #(
  parameter int AW         = 16,
  parameter int THRESH     = 8,
  parameter int MIN_PERIOD = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_tape,
  input  logic          arm,
  input  logic          cass_out,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  output logic [AW-1:0] length,
  output logic          active,
  output logic          frame_err,
  output logic          overflow
);

  // state  | meaning
  // OFF    | idle, waiting for arm to rise
  // WAIT   | armed, waiting for the first edge (no timeout here)
  // HUNT   | reading leader 1s, a 0 is the start bit
  // DATA   | shifting 8 data bits, LSB first
  // STOP1  | expecting first stop bit (1)
  // STOP2  | expecting second stop bit (1), commits the byte
  // END    | recording closed by timeout, waits for arm cycle
  typedef enum logic [2:0] {
    S_OFF, S_WAIT, S_HUNT, S_DATA, S_STOP1, S_STOP2, S_END
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync;
  logic        r_sync_d;
  logic        r_arm_d;
  logic [11:0] r_cnt;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;

  logic w_rise, w_accept, w_bit, w_timeout, w_arm_rise, w_full;

  assign w_rise     = r_sync[1] & ~r_sync_d;
  assign w_accept   = w_rise && (r_cnt >= 12'(MIN_PERIOD));
  assign w_bit      = (r_cnt >= 12'(THRESH));
  assign w_timeout  = (r_cnt >= 12'(TIMEOUT));
  assign w_arm_rise = arm & ~r_arm_d;
  assign w_full     = (length == {AW{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_OFF;
      r_sync    <= 2'b00;
      r_sync_d  <= 1'b0;
      r_arm_d   <= 1'b0;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      length    <= '0;
      active    <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], cass_out};
      r_sync_d <= r_sync[1];
      r_arm_d  <= arm;
      mem_we   <= 1'b0;

      // a rise coinciding with ce_tape is classified on the old count, then cleared
      if (w_accept)
        r_cnt <= '0;
      else if (ce_tape && (r_cnt != 12'hFFF))
        r_cnt <= r_cnt + 12'd1;

      if (mem_we)
        length <= length + 1'b1;

      case (r_state)
        S_OFF, S_END: ;
        S_WAIT: begin
          if (w_accept) begin
            r_state <= S_HUNT;
            active  <= 1'b1;
          end
        end
        S_HUNT: begin
          if (w_accept) begin
            if (!w_bit) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end
          end else if (w_timeout) begin
            r_state <= S_END;
            active  <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7)
              r_state <= S_STOP1;
          end else if (w_timeout) begin
            r_state <= S_END;
            active  <= 1'b0;
          end
        end
        S_STOP1: begin
          if (w_accept) begin
            if (w_bit) begin
              r_state <= S_STOP2;
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_HUNT;
            end
          end else if (w_timeout) begin
            r_state <= S_END;
            active  <= 1'b0;
          end
        end
        S_STOP2: begin
          if (w_accept) begin
            r_state <= S_HUNT;
            if (!w_bit) begin
              frame_err <= 1'b1;
            end else if (w_full) begin
              overflow <= 1'b1;
            end else begin
              mem_we   <= 1'b1;
              mem_addr <= length;
              mem_data <= r_shift;
            end
          end else if (w_timeout) begin
            r_state <= S_END;
            active  <= 1'b0;
          end
        end
        default: r_state <= S_OFF;
      endcase

      // disarm overrides the state update above but still lets a same-clk commit through
      if ((r_state != S_OFF) && !arm) begin
        r_state <= S_OFF;
        active  <= 1'b0;
      end

      if ((r_state == S_OFF) && w_arm_rise) begin
        r_state   <= S_WAIT;
        length    <= '0;
        frame_err <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tape_rec.sv
// Bench for tape_rec: two instances (AW=16 and AW=4) share one cassette stream;
// a frame-level model queues expected RAM writes for per-instance monitors.
module tb_tape_rec;

  logic        clk = 1'b0;
  logic        reset_n, ce_tape, arm, cass_out;
  logic [15:0] m16_addr, m16_len;
  logic [7:0]  m16_data;
  logic        m16_we, m16_active, m16_ferr, m16_ovf;
  logic [3:0]  m4_addr, m4_len;
  logic [7:0]  m4_data;
  logic        m4_we, m4_active, m4_ferr, m4_ovf;

  int checks = 0;
  int errors = 0;
  int q16[$];
  int q4[$];
  int cnt = 0;
  bit ferr = 1'b0;

  always #5 clk = ~clk;

  tape_rec #(.AW(16), .THRESH(8), .MIN_PERIOD(2), .TIMEOUT(1000)) dut (
    .clk(clk), .reset_n(reset_n), .ce_tape(ce_tape), .arm(arm), .cass_out(cass_out),
    .mem_addr(m16_addr), .mem_data(m16_data), .mem_we(m16_we), .length(m16_len),
    .active(m16_active), .frame_err(m16_ferr), .overflow(m16_ovf));

  tape_rec #(.AW(4), .THRESH(8), .MIN_PERIOD(2), .TIMEOUT(1000)) dut4 (
    .clk(clk), .reset_n(reset_n), .ce_tape(ce_tape), .arm(arm), .cass_out(cass_out),
    .mem_addr(m4_addr), .mem_data(m4_data), .mem_we(m4_we), .length(m4_len),
    .active(m4_active), .frame_err(m4_ferr), .overflow(m4_ovf));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // tick strobe every 4 clks
  initial begin
    ce_tape = 1'b0;
    forever begin
      @(negedge clk) ce_tape = 1'b1;
      @(negedge clk) ce_tape = 1'b0;
      nclk(2);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m16_we) begin
        if (q16.size() == 0) chk("unexpected_we16", int'({m16_addr, m16_data}), -1);
        else chk("write16", int'({m16_addr, m16_data}), q16.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m4_we) begin
        if (q4.size() == 0) chk("unexpected_we4", int'({m4_addr, m4_data}), -1);
        else chk("write4", int'({m4_addr, m4_data}), q4.pop_front());
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // one cassette cycle of p ticks; optional 1-tick glitch right after the rise
  task automatic cyc(input int p, input bit gl);
    cass_out = 1'b1;
    if (gl) begin
      nclk(2);
      cass_out = 1'b0;
      nclk(2);
      cass_out = 1'b1;
      nclk(2 * p - 4);
    end else begin
      nclk(2 * p);
    end
    cass_out = 1'b0;
    nclk(2 * p);
  endtask

  task automatic leader(input int n);
    for (int i = 0; i < n; i++) cyc(12, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit s1, input bit s2, input bit gl);
    bit gdone = 1'b0;
    cyc(4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        cyc(12, gl && !gdone);
        gdone = gl;
      end else begin
        cyc(4, 1'b0);
      end
    end
    cyc(s1 ? 12 : 4, 1'b0);
    if (s1) cyc(s2 ? 12 : 4, 1'b0);
    if (s1 && s2) begin
      q16.push_back((cnt << 8) | int'(b));
      if (cnt < 15) q4.push_back((cnt << 8) | int'(b));
      cnt++;
    end else begin
      ferr = 1'b1;
    end
  endtask

  task automatic check_status(input string tag, input bit exp_active);
    chk({tag, ".len16"}, int'(m16_len), cnt);
    chk({tag, ".len4"}, int'(m4_len), (cnt > 15) ? 15 : cnt);
    chk({tag, ".active16"}, int'(m16_active), int'(exp_active));
    chk({tag, ".active4"}, int'(m4_active), int'(exp_active));
    chk({tag, ".ferr16"}, int'(m16_ferr), int'(ferr));
    chk({tag, ".ferr4"}, int'(m4_ferr), int'(ferr));
    chk({tag, ".ovf16"}, int'(m16_ovf), 0);
    chk({tag, ".ovf4"}, int'(m4_ovf), (cnt > 15) ? 1 : 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".zero16"}, int'({m16_addr, m16_data, m16_we, m16_len, m16_active, m16_ferr, m16_ovf}), 0);
    chk({tag, ".zero4"}, int'({m4_addr, m4_data, m4_we, m4_len, m4_active, m4_ferr, m4_ovf}), 0);
  endtask

  task automatic rearm(input string tag);
    arm = 1'b0;
    nclk(4);
    chk({tag, ".off_active16"}, int'(m16_active), 0);
    chk({tag, ".pending16"}, q16.size(), 0);
    chk({tag, ".pending4"}, q4.size(), 0);
    cnt  = 0;
    ferr = 1'b0;
    arm  = 1'b1;
    nclk(4);
    chk({tag, ".armed_len16"}, int'(m16_len), 0);
  endtask

  task automatic close_rec(input string tag);
    leader(2);
    nclk(4);
    check_status(tag, 1'b1);
  endtask

  initial begin
    reset_n  = 1'b0;
    arm      = 1'b0;
    cass_out = 1'b0;
    nclk(3);
    check_zero("reset");
    reset_n = 1'b1;
    nclk(3);

    rearm("t1");
    leader(4);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    close_rec("t1");

    rearm("t2");
    leader(3);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    close_rec("t2");

    rearm("t3");
    leader(3);
    send_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
    leader(2);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    leader(1);
    send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
    close_rec("t3");

    rearm("t4");
    leader(3);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    close_rec("t4");

    rearm("t5");
    leader(3);
    for (int i = 0; i < 16; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
      leader(1);
    end
    close_rec("t5");

    rearm("t7");
    leader(3);
    for (int i = 0; i < 12; i++) begin
      int kind;
      kind = int'($urandom_range(0, 5));
      send_frame(8'($urandom), kind != 0, kind != 1, $urandom_range(0, 2) == 0);
      leader(int'($urandom_range(1, 3)));
    end
    close_rec("t7");

    nclk(4200);
    check_status("t6_timeout", 1'b0);
    leader(2);
    nclk(4);
    check_status("t6_after_end", 1'b0);

    rearm("t6r");
    leader(3);
    cyc(4, 1'b0);
    cyc(12, 1'b0);
    cyc(4, 1'b0);
    cass_out = 1'b1;
    nclk(5);
    #1 reset_n = 1'b0;
    #1 check_zero("midbyte_reset");
    cass_out = 1'b0;
    arm = 1'b0;
    nclk(2);
    reset_n = 1'b1;
    nclk(3);
    check_zero("post_reset");
    chk("t6r.pending16", q16.size(), 0);
    cnt  = 0;
    ferr = 1'b0;
    arm  = 1'b1;
    nclk(4);
    leader(3);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    close_rec("t6r");

    arm = 1'b0;
    nclk(8);
    chk("final.pending16", q16.size(), 0);
    chk("final.pending4", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
